// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: turns load-use, redirect, multi-cycle ALU and
// bus wait-state conditions into per-stage stall/flush commands.
module hazard_ctrl #(
  parameter int AWIDTH       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int BUS_TIMEOUT  = 15,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 hc_clk,
  input  logic                 hc_rst,
  input  logic                 hc_i_ce,
  input  logic                 hc_ds_valid,
  input  logic [AWIDTH-1:0]    hc_ds_addr_rs1,
  input  logic [AWIDTH-1:0]    hc_ds_addr_rs2,
  input  logic                 hc_ex_valid,
  input  logic                 hc_ex_is_load,
  input  logic                 hc_ex_we_reg,
  input  logic [AWIDTH-1:0]    hc_ex_addr_rd,
  input  logic                 hc_ex_change_pc,
  input  logic                 hc_ex_stall_from_alu,
  input  logic                 hc_me_cyc,
  input  logic                 hc_me_ack,
  output logic                 hc_o_stall_fi,
  output logic                 hc_o_stall_ds,
  output logic                 hc_o_stall_ex,
  output logic                 hc_o_flush_fi,
  output logic                 hc_o_flush_ds,
  output logic                 hc_o_flush_ex,
  output logic                 hc_o_bus_err,
  output logic [1:0]           hc_o_state,
  output logic [CNT_WIDTH-1:0] hc_o_stall_cnt
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam int TOW = $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM = 2'd2, ALU = 2'd3} state_t;

  state_t               state, state_nxt;
  logic [FCW-1:0]       fcnt, fcnt_nxt;
  logic [TOW-1:0]       tcnt, tcnt_nxt;
  logic                 bus_err_q, err_nxt;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic                 stall_fi, stall_ds, stall_ex;
  logic                 flush_fi, flush_ds, flush_ex;
  logic                 load_use, timeout_hit, gate;

  assign load_use = hc_ds_valid & hc_ex_valid & hc_ex_is_load & hc_ex_we_reg &
                    (hc_ex_addr_rd != '0) &
                    ((hc_ex_addr_rd == hc_ds_addr_rs1) | (hc_ex_addr_rd == hc_ds_addr_rs2));

  // The RUN cycle that raised the wait counts as one waited cycle, so the
  // abort lands after BUS_TIMEOUT stalled cycles in total.
  assign timeout_hit = (int'(tcnt) + 1) >= (BUS_TIMEOUT - 1);

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    tcnt_nxt  = tcnt;
    err_nxt   = 1'b0;
    stall_fi  = 1'b0;
    stall_ds  = 1'b0;
    stall_ex  = 1'b0;
    flush_fi  = 1'b0;
    flush_ds  = 1'b0;
    flush_ex  = 1'b0;
    case (state)
      RUN: begin
        if (hc_ex_change_pc) begin
          flush_fi  = 1'b1;
          flush_ds  = 1'b1;
          state_nxt = FLUSH;
          fcnt_nxt  = FCW'(FLUSH_CYCLES - 1);
        end else if (hc_me_cyc && !hc_me_ack) begin
          stall_fi  = 1'b1;
          stall_ds  = 1'b1;
          stall_ex  = 1'b1;
          state_nxt = MEM;
          tcnt_nxt  = '0;
        end else if (hc_ex_stall_from_alu) begin
          stall_fi  = 1'b1;
          stall_ds  = 1'b1;
          state_nxt = ALU;
        end else if (load_use) begin
          stall_fi = 1'b1;
          stall_ds = 1'b1;
          flush_ex = 1'b1;
        end
      end
      FLUSH: begin
        flush_fi = 1'b1;
        flush_ds = 1'b1;
        if (hc_ex_change_pc)   fcnt_nxt  = FCW'(FLUSH_CYCLES - 1);
        else if (fcnt == '0)   state_nxt = RUN;
        else                   fcnt_nxt  = fcnt - 1'b1;
      end
      MEM: begin
        stall_fi = 1'b1;
        stall_ds = 1'b1;
        stall_ex = 1'b1;
        if (hc_me_ack) begin
          state_nxt = RUN;
        end else if (timeout_hit) begin
          state_nxt = RUN;
          err_nxt   = 1'b1;
          flush_ex  = 1'b1;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      ALU: begin
        if (hc_ex_stall_from_alu) begin
          stall_fi = 1'b1;
          stall_ds = 1'b1;
        end else if (hc_ex_change_pc) begin
          flush_fi  = 1'b1;
          flush_ds  = 1'b1;
          state_nxt = FLUSH;
          fcnt_nxt  = FCW'(FLUSH_CYCLES - 1);
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge hc_clk) begin
    if (hc_rst) begin
      state     <= RUN;
      fcnt      <= '0;
      tcnt      <= '0;
      bus_err_q <= 1'b0;
      stall_cnt <= '0;
    end else if (hc_i_ce) begin
      state     <= state_nxt;
      fcnt      <= fcnt_nxt;
      tcnt      <= tcnt_nxt;
      bus_err_q <= err_nxt;
      if (stall_fi && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Reset and a disabled controller both silence every command.
  assign gate           = hc_i_ce & ~hc_rst;
  assign hc_o_stall_fi  = stall_fi & gate;
  assign hc_o_stall_ds  = stall_ds & gate;
  assign hc_o_stall_ex  = stall_ex & gate;
  assign hc_o_flush_fi  = flush_fi & gate;
  assign hc_o_flush_ds  = flush_ds & gate;
  assign hc_o_flush_ex  = flush_ex & gate;
  assign hc_o_bus_err   = bus_err_q & gate;
  assign hc_o_state     = state;
  assign hc_o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle comparison against a behavioural
// model plus literal expectations for each scenario.
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int FC = 2;
  localparam int BT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ce, ds_valid, ex_valid, is_load, we_reg, change_pc, alu, cyc, ack;
  logic [AW-1:0] rs1, rs2, rd;
  logic sfi, sds, sex, ffi, fds, fex, berr;
  logic [1:0] st;
  logic [15:0] cnt16;
  logic sfi4, sds4, sex4, ffi4, fds4, fex4, berr4;
  logic [1:0] st4;
  logic [3:0] cnt4;

  hazard_ctrl #(.AWIDTH(AW), .FLUSH_CYCLES(FC), .BUS_TIMEOUT(BT), .CNT_WIDTH(16)) dut (
    .hc_clk(clk), .hc_rst(rst), .hc_i_ce(ce), .hc_ds_valid(ds_valid),
    .hc_ds_addr_rs1(rs1), .hc_ds_addr_rs2(rs2), .hc_ex_valid(ex_valid),
    .hc_ex_is_load(is_load), .hc_ex_we_reg(we_reg), .hc_ex_addr_rd(rd),
    .hc_ex_change_pc(change_pc), .hc_ex_stall_from_alu(alu), .hc_me_cyc(cyc),
    .hc_me_ack(ack), .hc_o_stall_fi(sfi), .hc_o_stall_ds(sds), .hc_o_stall_ex(sex),
    .hc_o_flush_fi(ffi), .hc_o_flush_ds(fds), .hc_o_flush_ex(fex),
    .hc_o_bus_err(berr), .hc_o_state(st), .hc_o_stall_cnt(cnt16));

  hazard_ctrl #(.AWIDTH(AW), .FLUSH_CYCLES(FC), .BUS_TIMEOUT(BT), .CNT_WIDTH(4)) dut4 (
    .hc_clk(clk), .hc_rst(rst), .hc_i_ce(ce), .hc_ds_valid(ds_valid),
    .hc_ds_addr_rs1(rs1), .hc_ds_addr_rs2(rs2), .hc_ex_valid(ex_valid),
    .hc_ex_is_load(is_load), .hc_ex_we_reg(we_reg), .hc_ex_addr_rd(rd),
    .hc_ex_change_pc(change_pc), .hc_ex_stall_from_alu(alu), .hc_me_cyc(cyc),
    .hc_me_ack(ack), .hc_o_stall_fi(sfi4), .hc_o_stall_ds(sds4), .hc_o_stall_ex(sex4),
    .hc_o_flush_fi(ffi4), .hc_o_flush_ds(fds4), .hc_o_flush_ex(fex4),
    .hc_o_bus_err(berr4), .hc_o_state(st4), .hc_o_stall_cnt(cnt4));

  int n_chk = 0;
  int n_pass = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endfunction

  // Model: remaining flush cycles, total cycles waited on the bus, ALU busy flag.
  int  flush_rem = 0;
  int  mem_wait = 0;
  bit  in_mem = 0, in_alu = 0, err_pend = 0, known = 0, timeout_now, lu;
  longint stall_total = 0;
  bit  e_sfi, e_sds, e_sex, e_ffi, e_fds, e_fex, e_err;
  int  e_state;
  int  seg_ffi = 0, seg_sfi = 0, seg_sex = 0, seg_fex = 0, seg_err = 0;

  always @(negedge clk) begin
    {e_sfi, e_sds, e_sex, e_ffi, e_fds, e_fex, e_err} = '0;
    timeout_now = 0;
    if (rst) begin
      check("rst_stall_fi", 32'(sfi), 0);
      check("rst_stall_ex", 32'(sex), 0);
      check("rst_flush_fi", 32'(ffi), 0);
      check("rst_bus_err", 32'(berr), 0);
      if (known) begin
        check("rst_state", 32'(st), 0);
        check("rst_cnt", 32'(cnt16), 0);
      end
      flush_rem = 0; mem_wait = 0; in_mem = 0; in_alu = 0; err_pend = 0;
      stall_total = 0; known = 1;
    end else if (known) begin
      e_state = (flush_rem > 0) ? 1 : in_mem ? 2 : in_alu ? 3 : 0;
      e_err = err_pend & ce;
      lu = ds_valid && ex_valid && is_load && we_reg && rd != 0 && (rd == rs1 || rd == rs2);
      if (ce) begin
        if (flush_rem > 0) begin
          e_ffi = 1; e_fds = 1;
          flush_rem = change_pc ? FC : flush_rem - 1;
        end else if (in_mem) begin
          e_sfi = 1; e_sds = 1; e_sex = 1;
          mem_wait++;
          if (ack) in_mem = 0;
          else if (mem_wait >= BT) begin in_mem = 0; e_fex = 1; timeout_now = 1; end
        end else if (in_alu) begin
          if (alu) begin e_sfi = 1; e_sds = 1; end
          else begin
            in_alu = 0;
            if (change_pc) begin e_ffi = 1; e_fds = 1; flush_rem = FC; end
          end
        end else if (change_pc) begin
          e_ffi = 1; e_fds = 1; flush_rem = FC;
        end else if (cyc && !ack) begin
          e_sfi = 1; e_sds = 1; e_sex = 1; in_mem = 1; mem_wait = 1;
        end else if (alu) begin
          e_sfi = 1; e_sds = 1; in_alu = 1;
        end else if (lu) begin
          e_sfi = 1; e_sds = 1; e_fex = 1;
        end
      end
      check("stall_fi", 32'(sfi), 32'(e_sfi));
      check("stall_ds", 32'(sds), 32'(e_sds));
      check("stall_ex", 32'(sex), 32'(e_sex));
      check("flush_fi", 32'(ffi), 32'(e_ffi));
      check("flush_ds", 32'(fds), 32'(e_fds));
      check("flush_ex", 32'(fex), 32'(e_fex));
      check("bus_err", 32'(berr), 32'(e_err));
      check("state", 32'(st), 32'(e_state));
      check("stall_cnt16", 32'(cnt16), 32'((stall_total > 65535) ? 65535 : stall_total));
      check("stall_cnt4", 32'(cnt4), 32'((stall_total > 15) ? 15 : stall_total));
      if (ce) begin
        stall_total += e_sfi;
        err_pend = timeout_now;
      end
    end
    if (!rst) begin
      seg_ffi += ffi; seg_sfi += sfi; seg_sex += sex; seg_fex += fex; seg_err += berr;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ce = 1; ds_valid = 0; ex_valid = 0; is_load = 0; we_reg = 0; change_pc = 0;
    alu = 0; cyc = 0; ack = 0; rs1 = 0; rs2 = 0; rd = 0;
  endtask

  task automatic seg_clear();
    seg_ffi = 0; seg_sfi = 0; seg_sex = 0; seg_fex = 0; seg_err = 0;
  endtask

  task automatic set_load_use(input logic [AW-1:0] d, input logic [AW-1:0] s1);
    ex_valid = 1; is_load = 1; we_reg = 1; rd = d; ds_valid = 1; rs1 = s1; rs2 = 0;
  endtask

  initial begin
    idle();
    rst = 1; cyc = 1;
    repeat (3) tick();
    check("lit_rst_state", 32'(st), 0);
    check("lit_rst_stall", 32'(sfi), 0);
    check("lit_rst_cnt", 32'(cnt16), 0);
    rst = 0; idle();
    tick();

    // load-use on rs1 with rd=5, then with rd=0
    set_load_use(5'd5, 5'd5);
    @(negedge clk); #1;
    check("lit_lu_stall", 32'({sfi, sds, fex}), 32'h7);
    tick(); idle();
    check("lit_lu_cnt", 32'(cnt16), 1);
    set_load_use(5'd0, 5'd0);
    @(negedge clk); #1;
    check("lit_lu_r0", 32'(sfi), 0);
    tick(); idle(); tick();

    // branch flush, then redirect again in the 2nd FLUSH cycle
    seg_clear();
    change_pc = 1; tick(); idle();
    repeat (4) tick();
    check("lit_br_len", 32'(seg_ffi), 3);
    check("lit_br_state", 32'(st), 0);
    seg_clear();
    change_pc = 1; tick(); change_pc = 0; tick();
    change_pc = 1; tick(); change_pc = 0;
    repeat (4) tick();
    check("lit_br2_len", 32'(seg_ffi), 5);

    // bus wait, ack on 4th cycle
    seg_clear();
    cyc = 1; repeat (3) tick(); ack = 1; tick(); idle();
    tick();
    check("lit_bw_stall", 32'(seg_sex), 4);
    check("lit_bw_err", 32'(seg_err), 0);
    check("lit_bw_state", 32'(st), 0);

    // bus timeout
    seg_clear();
    cyc = 1; repeat (BT) tick(); idle();
    repeat (2) tick();
    check("lit_to_stall", 32'(seg_sex), 15);
    check("lit_to_err", 32'(seg_err), 1);
    check("lit_to_fex", 32'(seg_fex), 1);

    // redirect wins over load-use
    seg_clear();
    set_load_use(5'd7, 5'd7); change_pc = 1;
    @(negedge clk); #1;
    check("lit_pri_ffi", 32'(ffi), 1);
    check("lit_pri_stall", 32'({sfi, fex}), 0);
    tick(); idle();
    repeat (4) tick();
    check("lit_pri_len", 32'(seg_ffi), 3);
    check("lit_pri_nostall", 32'(seg_sfi), 0);

    // ALU busy then release with redirect
    seg_clear();
    alu = 1; repeat (3) tick(); alu = 0; change_pc = 1; tick(); idle();
    repeat (4) tick();
    check("lit_alu_stall", 32'(seg_sfi), 3);
    check("lit_alu_flush", 32'(seg_ffi), 3);

    // enable low during a bus wait
    cyc = 1; repeat (2) tick();
    ce = 0; repeat (2) tick();
    @(negedge clk); #1;
    check("lit_ce_stall", 32'(sfi), 0);
    check("lit_ce_state", 32'(st), 2);
    tick(); ce = 1; ack = 1; tick(); idle();
    tick();
    check("lit_ce_exit", 32'(st), 0);

    // saturation of the narrow counter
    alu = 1; repeat (20) tick(); alu = 0; tick(); idle();
    tick();
    check("lit_sat4", 32'(cnt4), 15);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
